// File: rtl/ins_fetch_pkg.sv
// ins_fetch_pkg: types and constants shared by the instruction-fetch stage.
//   state_t    : FETCH / FLUSH encoding of the fetch FSM
//   id_t       : registered instruction + exception tags handed to ID
//   NOP_INS    : instruction used for misaligned-PC and interrupt slots
//   RST_PC_DEF : default reset PC
package ins_fetch_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  localparam logic [31:0] NOP_INS    = 32'h0000_0013;
  localparam logic [63:0] RST_PC_DEF = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic        valid;
    logic [31:0] ins;
    logic [63:0] pc;
    logic        acc_fault;
    logic        addr_mis;
    logic        page_fault;
    logic        int_acc;
  } id_t;

  // Empty slot: ins/pc keep their last value, valid and tags drop.
  function automatic id_t id_bubble(input id_t cur);
    id_t r;
    r            = cur;
    r.valid      = 1'b0;
    r.acc_fault  = 1'b0;
    r.addr_mis   = 1'b0;
    r.page_fault = 1'b0;
    r.int_acc    = 1'b0;
    return r;
  endfunction

  // Synthetic NOP slot carrying either the misaligned or the interrupt tag.
  function automatic id_t id_nop_slot(input logic [63:0] pc, input logic mis, input logic intr);
    id_t r;
    r            = '0;
    r.valid      = 1'b1;
    r.ins        = NOP_INS;
    r.pc         = pc;
    r.addr_mis   = mis;
    r.int_acc    = intr;
    return r;
  endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// ins_fetch_if: fetch bus between the IF stage and the instruction memory.
//   ifu_req/ifu_addr              : request, address held until ifu_ack
//   ifu_ack/ifu_rdata/ifu_*_fault : response, valid with ifu_ack
//   master = fetch stage, slave = memory side
interface ins_fetch_if;
  logic        ifu_req;
  logic [63:0] ifu_addr;
  logic        ifu_ack;
  logic [31:0] ifu_rdata;
  logic        ifu_acc_fault;
  logic        ifu_page_fault;

  modport master (
    output ifu_req, ifu_addr,
    input  ifu_ack, ifu_rdata, ifu_acc_fault, ifu_page_fault
  );

  modport slave (
    input  ifu_req, ifu_addr,
    output ifu_ack, ifu_rdata, ifu_acc_fault, ifu_page_fault
  );
endinterface

// File: rtl/ins_fetch_ifu_skid.sv
// ifu_skid: one-entry buffer catching a fetch response that lands while ID
// is stalled. Only instantiated when IFU_SKID_EN is defined.
//   clk, rst_n     : clock, async active-low reset
//   i_load         : capture i_ins/i_pc/i_acc_fault/i_page_fault
//   i_clr          : empty the entry (drain or redirect); wins over i_load
//   o_full         : entry holds a response
//   o_ins/o_pc/o_* : stored response
module ifu_skid (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_clr,
  input  logic [31:0] i_ins,
  input  logic [63:0] i_pc,
  input  logic        i_acc_fault,
  input  logic        i_page_fault,
  output logic        o_full,
  output logic [31:0] o_ins,
  output logic [63:0] o_pc,
  output logic        o_acc_fault,
  output logic        o_page_fault
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_full       <= 1'b0;
      o_ins        <= '0;
      o_pc         <= '0;
      o_acc_fault  <= 1'b0;
      o_page_fault <= 1'b0;
    end else if (i_clr) begin
      o_full       <= 1'b0;
    end else if (i_load) begin
      o_full       <= 1'b1;
      o_ins        <= i_ins;
      o_pc         <= i_pc;
      o_acc_fault  <= i_acc_fault;
      o_page_fault <= i_page_fault;
    end
  end

endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: instruction-fetch stage. Issues one fetch at a time on the
// ins_fetch_if bus and registers the instruction plus exception tags for ID.
// Optional macro IFU_SKID_EN adds a one-entry skid buffer so a response that
// arrives during if_hold is kept instead of refetched.
//   clk, rst_n          : clock, async active-low reset
//   bus (master)        : fetch request/response
//   i_if_nop, i_if_hold : bubble / stall commands from the pipeline controller
//   i_pc_jmp, i_new_pc  : redirect
//   i_int_req           : pending interrupt (level)
//   o_id_*              : registered instruction, pc, valid and tags to ID
//
// state | meaning
// FETCH | normal operation, a new request may be issued
// FLUSH | a request issued before a redirect is still outstanding; its ack is dropped
module ins_fetch
  import ins_fetch_pkg::*;
#(
  parameter logic [63:0] RST_PC = RST_PC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  ins_fetch_if.master bus,
  input  logic        i_if_nop,
  input  logic        i_if_hold,
  input  logic        i_pc_jmp,
  input  logic [63:0] i_new_pc,
  input  logic        i_int_req,
  output logic [31:0] o_id_ins,
  output logic [63:0] o_id_pc,
  output logic        o_id_valid,
  output logic        o_id_ins_acc_fault,
  output logic        o_id_ins_addr_mis,
  output logic        o_id_ins_page_fault,
  output logic        o_id_int_acc
);

`ifdef IFU_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt, r_addr, w_addr, w_pc_inc;
  logic        r_pend, w_pend_nxt, r_go;
  id_t         r_id, w_id_nxt;
  logic        w_new_req, w_req, w_ack, w_fault;
  logic        w_skid_full, w_skid_acc, w_skid_page;
  logic [31:0] w_skid_ins;
  logic [63:0] w_skid_pc;

  assign w_pc_inc = r_pc + 64'd4;
  // Once a request is out, its address is frozen even if pc is redirected.
  assign w_addr   = r_pend ? r_addr : r_pc;
  // r_go keeps ifu_req low in the first cycle after reset release.
  assign w_new_req = r_go && (r_state == ST_FETCH) && (r_pc[1:0] == 2'b00) &&
                     !w_skid_full && !i_int_req && !i_if_nop &&
                     (SKID_EN || !i_if_hold);
  assign w_req    = r_pend | w_new_req;
  assign w_ack    = w_req & bus.ifu_ack;
  assign w_fault  = bus.ifu_acc_fault | bus.ifu_page_fault;

  assign bus.ifu_req  = w_req;
  assign bus.ifu_addr = w_addr;

`ifdef IFU_SKID_EN
  logic w_skid_load, w_skid_clr;

  ifu_skid u_skid (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (w_skid_load),
    .i_clr        (w_skid_clr),
    .i_ins        (bus.ifu_rdata),
    .i_pc         (r_pc),
    .i_acc_fault  (bus.ifu_acc_fault),
    .i_page_fault (bus.ifu_page_fault),
    .o_full       (w_skid_full),
    .o_ins        (w_skid_ins),
    .o_pc         (w_skid_pc),
    .o_acc_fault  (w_skid_acc),
    .o_page_fault (w_skid_page)
  );
`else
  assign w_skid_full = 1'b0;
  assign w_skid_ins  = '0;
  assign w_skid_pc   = '0;
  assign w_skid_acc  = 1'b0;
  assign w_skid_page = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_pend_nxt  = w_req & ~bus.ifu_ack;
    w_id_nxt    = r_id;
`ifdef IFU_SKID_EN
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
`endif
    if (i_pc_jmp) begin
      w_pc_nxt    = i_new_pc;
      w_id_nxt    = id_bubble(r_id);
      w_state_nxt = w_pend_nxt ? ST_FLUSH : ST_FETCH;
`ifdef IFU_SKID_EN
      w_skid_clr  = 1'b1;
`endif
    end else if (r_state == ST_FLUSH) begin
      if (w_ack) w_state_nxt = ST_FETCH;
    end else if (i_if_nop) begin
      w_id_nxt = id_bubble(r_id);
    end else if (i_if_hold) begin
`ifdef IFU_SKID_EN
      if (w_ack) begin
        w_skid_load = 1'b1;
        if (!w_fault) w_pc_nxt = w_pc_inc;
      end
`endif
    end else if (w_skid_full) begin
      w_id_nxt            = '0;
      w_id_nxt.valid      = 1'b1;
      w_id_nxt.ins        = w_skid_ins;
      w_id_nxt.pc         = w_skid_pc;
      w_id_nxt.acc_fault  = w_skid_acc;
      w_id_nxt.page_fault = w_skid_page;
`ifdef IFU_SKID_EN
      w_skid_clr          = 1'b1;
`endif
    end else if (w_ack) begin
      w_id_nxt            = '0;
      w_id_nxt.valid      = 1'b1;
      w_id_nxt.ins        = bus.ifu_rdata;
      w_id_nxt.pc         = r_pc;
      w_id_nxt.acc_fault  = bus.ifu_acc_fault;
      w_id_nxt.page_fault = bus.ifu_page_fault;
      // A faulting fetch is reported at its own pc; ID decides the redirect.
      if (!w_fault) w_pc_nxt = w_pc_inc;
    end else if (!w_req && (r_pc[1:0] != 2'b00)) begin
      w_id_nxt = id_nop_slot(r_pc, 1'b1, 1'b0);
    end else if (!w_req && i_int_req) begin
      w_id_nxt = id_nop_slot(r_pc, 1'b0, 1'b1);
    end else begin
      w_id_nxt = id_bubble(r_id);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc   <= RST_PC;
      r_addr <= RST_PC;
      r_pend <= 1'b0;
      r_go   <= 1'b0;
      r_id   <= '0;
    end else begin
      r_pc   <= w_pc_nxt;
      r_addr <= w_addr;
      r_pend <= w_pend_nxt;
      r_go   <= 1'b1;
      r_id   <= w_id_nxt;
    end
  end

  assign o_id_valid          = r_id.valid;
  assign o_id_ins            = r_id.ins;
  assign o_id_pc             = r_id.pc;
  assign o_id_ins_acc_fault  = r_id.acc_fault;
  assign o_id_ins_addr_mis   = r_id.addr_mis;
  assign o_id_ins_page_fault = r_id.page_fault;
  assign o_id_int_acc        = r_id.int_acc;

endmodule

// File: doc/ins_fetch.md
INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 Parameter: RST_PC, 64'h0000_0000_8000_0000, PC loaded on reset.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 if_nop, if_hold  in  1 each  pipeline-controller commands for this stage.
REQ-006 pc_jmp  in  1, new_pc  in  64  redirect strobe and target from EX/WB.
REQ-007 int_req  in  1  pending interrupt, level.
REQ-008 ifu_req  out  1, ifu_addr  out  64  fetch request and address.
REQ-009 ifu_ack  in  1, ifu_rdata  in  32, ifu_acc_fault  in  1, ifu_page_fault  in  1  fetch response, valid with ifu_ack.
REQ-010 id_ins  out  32, id_pc  out  64, id_valid  out  1  registered instruction to ID.
REQ-011 id_ins_acc_fault, id_ins_addr_mis, id_ins_page_fault, id_int_acc  out  1 each  registered exception tags to ID.

Function
REQ-012 States: FETCH (ifu_req may assert), FLUSH (outstanding request to discard); HOLD sub-condition = skid entry full.
REQ-013 Bus: ifu_req with constant ifu_addr until ifu_ack sampled high, including the first cycle; at most one request outstanding.
REQ-014 ifu_addr = pc; ifu_req = 1 in FETCH only when pc[1:0]==0, skid empty, !int_req, !if_nop.
REQ-015 Ack in FETCH with !if_hold, !if_nop: next cycle id_valid=1, id_ins=ifu_rdata, id_pc=pc, fault tags copied; pc += 4 (mod 2^64).
REQ-016 Latency: ack at cycle N gives id_valid=1 at N+1.
REQ-017 pc[1:0]!=0 in FETCH: no bus request; emit id_valid=1, id_ins_addr_mis=1, id_ins=32'h0000_0013, id_pc=pc; pc unchanged.
REQ-018 int_req with no request outstanding and !if_nop/!if_hold: emit id_valid=1, id_int_acc=1, id_ins=32'h0000_0013, id_pc=pc; pc unchanged.
REQ-019 if_hold=1: all id_* hold their value; pc unchanged.
REQ-020 if_nop=1: id_valid cleared next cycle, all tags 0; any ack in that cycle discarded; pc unchanged (refetch).
REQ-021 pc_jmp=1 (priority over all): pc <= new_pc; id_valid cleared; skid cleared; request outstanding without ack this cycle -> FLUSH.
REQ-022 FLUSH: ifu_req held high at old address; next ack discarded; then FETCH at new pc.
REQ-023 pc_jmp during FLUSH: pc updated again; still one ack discarded.
REQ-024 Faulting fetch (acc/page) is delivered like any instruction; pc not advanced past it.

Reset
REQ-025 Reset: pc=RST_PC, state FETCH, skid empty, ifu_req=0, id_valid=0, id_ins=0, id_pc=0, all tags 0.
REQ-026 Reset mid-request: request abandoned; first post-reset ifu_req issued at cycle 1 after rst_n release.

Configuration
REQ-027 IFU_SKID_EN defined: one-entry skid buffer; ack during if_hold stored, pc += 4; skid drains to id_* first cycle !if_hold, before new request.
REQ-028 IFU_SKID_EN undefined: ack during if_hold discarded, pc unchanged, ifu_req suppressed while if_hold.

Structure
REQ-029 Shared package: state encoding, NOP_INS=32'h0000_0013, RST_PC default.
REQ-030 Sub-module ifu_skid (one-entry ins/pc/tag buffer) instantiated only under IFU_SKID_EN.

Verification
REQ-031 Reset release, ack after 2 cycles with rdata 32'h00A00093 -> id_valid=1, id_pc=64'h8000_0000, next ifu_addr=64'h8000_0004.
REQ-032 pc_jmp new_pc=64'h8000_0100 while request pending -> ack data discarded, next ifu_addr=64'h8000_0100, id_valid=0 until its ack.
REQ-033 new_pc=64'h8000_0102 -> no ifu_req, id_ins_addr_mis=1, id_ins=32'h00000013.
REQ-034 if_hold high 3 cycles, ack in first hold cycle -> id_* stable 3 cycles; with IFU_SKID_EN skid data on id_* 1 cycle after release, without it refetch of same address.
REQ-035 ifu_ack with ifu_page_fault=1 -> id_ins_page_fault=1, pc not advanced; if_nop next cycle -> id_valid=0.
REQ-036 int_req=1 with bus idle -> id_int_acc=1, id_pc=current pc, no ifu_req issued.
